// File: rtl/furv_mem_arbiter.sv
// furv_mem_arbiter: shares one single-port memory between the fetch port
// and the load/store port.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   if_req/if_addr        fetch request and pc
//   if_rdata/if_valid     fetched word and one-cycle completion pulse
//   d_req/d_we/d_addr     data request, store flag, address
//   d_wdata               store data
//   d_rdata/d_valid       load data and one-cycle completion pulse
//   stall                 core holds pc/regfile while an access is open
//   mem_req/mem_we        memory transaction request and write enable
//   mem_addr/mem_wdata    memory address and write data
//   mem_rdata/mem_ready   memory read data and completion strobe
//
// Build option: define FURV_ARB_FAIR_EN for alternating priority
// when both ports request together (default: data beats fetch).
module furv_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic              r_if_valid;
  logic              r_d_valid;

  // A port whose valid is high this cycle has just completed;
  // masking it stops the same request from being granted twice.
  logic w_if_pend;
  logic w_d_pend;
  logic w_pick_d;
  logic w_pick_i;

  logic w_grant_i;
  logic w_grant_d;
  logic w_done_i;
  logic w_done_d;

  assign w_if_pend = if_req & ~r_if_valid;
  assign w_d_pend  = d_req  & ~r_d_valid;

`ifdef FURV_ARB_FAIR_EN
  // 1 = data was granted most recently, 0 = fetch.
  logic r_last_d;

  // Under contention the port not served last wins.
  assign w_pick_d = w_d_pend & (~w_if_pend | ~r_last_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_d <= 1'b0;
    end else if (w_grant_d) begin
      r_last_d <= 1'b1;
    end else if (w_grant_i) begin
      r_last_d <= 1'b0;
    end
  end
`else
  assign w_pick_d = w_d_pend;
`endif

  assign w_pick_i = w_if_pend & ~w_pick_d;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_pick_d) begin
          w_state_nxt = BUSY_D;
        end else if (w_pick_i) begin
          w_state_nxt = BUSY_I;
        end
      end
      BUSY_I: begin
        if (mem_ready) begin
          w_state_nxt = IDLE;
        end
      end
      BUSY_D: begin
        if (mem_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output decode: grant and completion strobes
  always_comb begin
    w_grant_i = 1'b0;
    w_grant_d = 1'b0;
    w_done_i  = 1'b0;
    w_done_d  = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_grant_d = w_pick_d;
        w_grant_i = w_pick_i;
      end
      BUSY_I:  w_done_i = mem_ready;
      BUSY_D:  w_done_d = mem_ready;
      default: ;
    endcase
  end

  // Memory-side request registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else if (w_grant_d) begin
      r_mem_req   <= 1'b1;
      r_mem_we    <= d_we;
      r_mem_addr  <= d_addr;
      r_mem_wdata <= d_wdata;
    end else if (w_grant_i) begin
      r_mem_req   <= 1'b1;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= if_addr;
    end else if (w_done_i | w_done_d) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
    end
  end

  // Response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_if_valid <= 1'b0;
      r_d_valid  <= 1'b0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else begin
      r_if_valid <= w_done_i;
      r_d_valid  <= w_done_d;
      if (w_done_i) begin
        r_if_rdata <= mem_rdata;
      end
      // Stores leave the last load value in place.
      if (w_done_d && !r_mem_we) begin
        r_d_rdata <= mem_rdata;
      end
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign if_rdata  = r_if_rdata;
  assign if_valid  = r_if_valid;
  assign d_rdata   = r_d_rdata;
  assign d_valid   = r_d_valid;

  assign stall = (if_req & ~r_if_valid) | (d_req & ~r_d_valid);

endmodule

// File: tb/tb_furv_mem_arbiter.sv
// tb_furv_mem_arbiter: directed checks of furv_mem_arbiter.
// Drives both core ports and plays the memory side by hand.
module tb_furv_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  int checks = 0;
  int errors = 0;

  logic [31:0] first_addr;
  logic [31:0] second_addr;

  always #5 clk = ~clk;

  furv_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_valid  (if_valid),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_valid   (d_valid),
    .stall     (stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst       = 1'b1;
    if_req    = 1'b0;
    if_addr   = '0;
    d_req     = 1'b0;
    d_we      = 1'b0;
    d_addr    = '0;
    d_wdata   = '0;
    mem_rdata = '0;
    mem_ready = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_if_valid", if_valid, 0);
    chk("rst_d_valid", d_valid, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_stall", stall, 0);

    // Fetch, memory ready on first busy cycle
    if_req    = 1'b1;
    if_addr   = 32'h0000_0010;
    mem_ready = 1'b1;
    mem_rdata = 32'h0051_0113;
    #1;
    chk("f_stall_req", stall, 1);
    step();
    chk("f_mem_req", mem_req, 1);
    chk("f_mem_addr", mem_addr, 32'h10);
    chk("f_mem_we", mem_we, 0);
    chk("f_valid_early", if_valid, 0);
    chk("f_stall_busy", stall, 1);
    step();
    chk("f_valid", if_valid, 1);
    chk("f_rdata", if_rdata, 32'h0051_0113);
    chk("f_req_clr", mem_req, 0);
    chk("f_stall_done", stall, 0);
    if_req    = 1'b0;
    mem_ready = 1'b0;
    step();
    chk("f_valid_once", if_valid, 0);
    chk("f_idle_req", mem_req, 0);

    // Load with three wait cycles
    d_req     = 1'b1;
    d_we      = 1'b0;
    d_addr    = 32'h0000_0100;
    mem_rdata = 32'hCAFE_0001;
    step();
    chk("ld_req_b0", mem_req, 1);
    chk("ld_addr_b0", mem_addr, 32'h100);
    chk("ld_we_b0", mem_we, 0);
    for (int k = 1; k <= 3; k++) begin
      d_addr = 32'h0000_0999;
      step();
      chk($sformatf("ld_req_b%0d", k), mem_req, 1);
      chk($sformatf("ld_addr_b%0d", k), mem_addr, 32'h100);
      chk($sformatf("ld_we_b%0d", k), mem_we, 0);
      chk($sformatf("ld_valid_b%0d", k), d_valid, 0);
      chk($sformatf("ld_stall_b%0d", k), stall, 1);
    end
    mem_ready = 1'b1;
    step();
    chk("ld_valid", d_valid, 1);
    chk("ld_rdata", d_rdata, 32'hCAFE_0001);
    chk("ld_req_clr", mem_req, 0);
    chk("ld_if_valid", if_valid, 0);
    d_req     = 1'b0;
    mem_ready = 1'b0;
    step();
    chk("ld_valid_once", d_valid, 0);

    // Store, one wait cycle; read data must not land in d_rdata
    d_req     = 1'b1;
    d_we      = 1'b1;
    d_addr    = 32'h0000_0200;
    d_wdata   = 32'hDEAD_BEEF;
    mem_rdata = 32'h1234_5678;
    step();
    chk("st_we", mem_we, 1);
    chk("st_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("st_addr", mem_addr, 32'h200);
    d_wdata = 32'h0;
    step();
    chk("st_we_hold", mem_we, 1);
    chk("st_wdata_hold", mem_wdata, 32'hDEAD_BEEF);
    chk("st_req_hold", mem_req, 1);
    mem_ready = 1'b1;
    step();
    chk("st_valid", d_valid, 1);
    chk("st_rdata_keep", d_rdata, 32'hCAFE_0001);
    chk("st_we_clr", mem_we, 0);
    chk("st_req_clr", mem_req, 0);
    d_req     = 1'b0;
    d_we      = 1'b0;
    mem_ready = 1'b0;
    step();
    chk("st_valid_once", d_valid, 0);

    // Simultaneous requests; last grant was data
`ifdef FURV_ARB_FAIR_EN
    first_addr  = 32'h0000_0014;
    second_addr = 32'h0000_0300;
`else
    first_addr  = 32'h0000_0300;
    second_addr = 32'h0000_0014;
`endif
    if_req    = 1'b1;
    if_addr   = 32'h0000_0014;
    d_req     = 1'b1;
    d_we      = 1'b0;
    d_addr    = 32'h0000_0300;
    mem_ready = 1'b1;
    mem_rdata = 32'hAAAA_0000;
    step();
    chk("arb_first_addr", mem_addr, first_addr);
    chk("arb_first_req", mem_req, 1);
    step();
`ifdef FURV_ARB_FAIR_EN
    chk("arb_first_valid", if_valid, 1);
    chk("arb_first_rdata", if_rdata, 32'hAAAA_0000);
    chk("arb_other_idle", d_valid, 0);
    if_req = 1'b0;
`else
    chk("arb_first_valid", d_valid, 1);
    chk("arb_first_rdata", d_rdata, 32'hAAAA_0000);
    chk("arb_other_idle", if_valid, 0);
    d_req = 1'b0;
`endif
    chk("arb_stall_loser", stall, 1);
    mem_rdata = 32'hBBBB_0000;
    step();
    chk("arb_second_addr", mem_addr, second_addr);
    chk("arb_second_req", mem_req, 1);
    chk("arb_valid_drop_i", if_valid, 0);
    chk("arb_valid_drop_d", d_valid, 0);
    step();
`ifdef FURV_ARB_FAIR_EN
    chk("arb_second_valid", d_valid, 1);
    chk("arb_second_rdata", d_rdata, 32'hBBBB_0000);
    d_req = 1'b0;
`else
    chk("arb_second_valid", if_valid, 1);
    chk("arb_second_rdata", if_rdata, 32'hBBBB_0000);
    if_req = 1'b0;
`endif
    mem_ready = 1'b0;
    step();
    chk("arb_idle", mem_req, 0);

    // Reset while a load is waiting on memory
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h0000_0400;
    step();
    chk("rb_req", mem_req, 1);
    chk("rb_addr", mem_addr, 32'h400);
    rst = 1'b1;
    step();
    chk("rb_req_clr", mem_req, 0);
    chk("rb_addr_clr", mem_addr, 0);
    chk("rb_no_valid", d_valid, 0);
    rst       = 1'b0;
    d_req     = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 32'h5555_5555;
    step();
    chk("rb_still_idle", mem_req, 0);
    chk("rb_no_valid2", d_valid, 0);
    chk("rb_rdata_clr", d_rdata, 0);
    if_req    = 1'b1;
    if_addr   = 32'h0000_0020;
    mem_rdata = 32'h0000_1111;
    step();
    chk("rb_f_addr", mem_addr, 32'h20);
    chk("rb_f_req", mem_req, 1);
    step();
    chk("rb_f_valid", if_valid, 1);
    chk("rb_f_rdata", if_rdata, 32'h0000_1111);
    if_req = 1'b0;
    step();

    // mem_ready while idle with nothing pending
    mem_ready = 1'b1;
    mem_rdata = 32'h7777_7777;
    step();
    chk("idle_rdy_req", mem_req, 0);
    chk("idle_rdy_iv", if_valid, 0);
    chk("idle_rdy_dv", d_valid, 0);
    step();
    chk("idle_rdy_iv2", if_valid, 0);
    chk("idle_rdy_dv2", d_valid, 0);
    chk("idle_rdy_ir", if_rdata, 32'h0000_1111);
    mem_ready = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/furv_mem_arbiter.md
Name: furv_mem_arbiter

Overview:
- Shares one single-port memory between the core's instruction-fetch port and its load/store port.
- Sequences each access as a req/ready transaction on the memory side.
- Returns a one-cycle valid pulse with read data to the winning requester.
- Drives a stall to the core while any of the core's accesses is still outstanding.

Parameters:
ADDR_W, 32, width of all address buses
DATA_W, 32, width of all data buses

Ports:
clk  in  1  core clock; all state updates on posedge
rst  in  1  synchronous, active-high reset
if_req  in  1  fetch request; held high until if_valid
if_addr  in  ADDR_W  fetch address (pc); stable while if_req
if_rdata  out  DATA_W  fetched instruction; valid when if_valid
if_valid  out  1  one-cycle fetch completion pulse
d_req  in  1  data request; held high until d_valid
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_rdata  out  DATA_W  load data; valid when d_valid
d_valid  out  1  one-cycle data completion pulse (loads and stores)
stall  out  1  core must hold pc/regfile this cycle
mem_req  out  1  memory transaction request
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data; sampled when mem_ready
mem_ready  in  1  memory completes current transaction this cycle

Behaviour:
- Clock/reset: one clock, clk. rst is synchronous and active-high.
- Reset values: FSM=IDLE; mem_req, mem_we, if_valid, d_valid = 0; mem_addr, mem_wdata, if_rdata, d_rdata = 0.
- Reset mid-transaction: aborts the transaction; mem_req is 0 after the reset edge; no valid pulse is issued.
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE:
  - Each posedge samples the requests.
  - Default priority is data > fetch.
  - Grant D: latch d_addr, d_we, d_wdata into mem_addr, mem_we, mem_wdata; set mem_req=1; go to BUSY_D.
  - Grant I: latch if_addr into mem_addr; set mem_we=0, mem_req=1; go to BUSY_I.
  - No request: stay in IDLE; mem_req=0.
- BUSY_x:
  - mem_req, mem_we, mem_addr and mem_wdata are held unchanged until mem_ready is sampled high.
  - On the edge where mem_ready=1: capture mem_rdata into x_rdata (loads/fetches only; d_rdata unchanged on stores).
  - Same edge: set x_valid=1 for exactly one cycle, clear mem_req and mem_we, return to IDLE.
- mem_ready is ignored in IDLE.
- Latency: request sampled at edge N; mem_req high after N. With mem_ready=1 immediately, x_valid is high in the cycle after N+1. Minimum is 2 cycles per access. Each additional cycle of mem_ready low adds one cycle.
- Re-request rule: a requester deasserts req during its valid cycle. The arbiter masks x_req while x_valid=1, so a completed request is never re-granted. The other requester may be granted at that same edge.
- Stall is combinational: stall = (if_req & ~if_valid) | (d_req & ~d_valid).
- Requests changing while their port is not granted are legal; only the values at the grant edge are used.
- Simultaneous if_req and d_req: one grant only. The loser stays pending and is granted at the first IDLE edge after the winner's valid.

Optional Feature:
- Macro: FURV_ARB_FAIR_EN.
- Defined: a last_grant flop (reset = fetch) records the most recent grant. When both requests are pending in IDLE, the port not granted last wins. A single requester always wins.
- Undefined: fixed priority, data always beats fetch; no last_grant flop.

Test Plan:
- Reset, then if_req=1, if_addr=0x0000_0010, memory returns 0x0051_0113 with mem_ready at the first BUSY cycle -> mem_req/mem_addr=0x10 the cycle after the request edge; if_valid=1 with if_rdata=0x0051_0113 exactly one cycle; stall=1 until then.
- Load d_addr=0x0000_0100 with mem_ready delayed 3 cycles -> mem_addr held 0x100, mem_we=0 for all 4 BUSY cycles; d_valid pulses once, d_rdata=mem_rdata; total latency 5 cycles.
- Store d_we=1, d_addr=0x200, d_wdata=0xDEAD_BEEF -> mem_we=1, mem_wdata=0xDEAD_BEEF held until ready; d_valid pulses; d_rdata unchanged.
- if_req and d_req asserted in the same cycle, default build -> data granted first, fetch granted on the d_valid edge. With FURV_ARB_FAIR_EN and last_grant=data -> fetch granted first.
- rst asserted while in BUSY_D with mem_ready low -> after the edge mem_req=0, FSM IDLE, no d_valid; a subsequent fetch completes normally.
- mem_ready pulsed while IDLE with no requests -> no state change, no valid pulses.
